// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer types and Gray/binary conversion shared by both sides of the dual-clock FIFO.
package fifo_pkg;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int DEF_ADDR_WIDTH = 8;
    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;
    // Width-agnostic: callers zero-extend to 32 bits and size-cast the result back.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/ptr_sync.sv
// ptr_sync: multi-flop synchronizer for a Gray pointer crossing into the local clock domain.
module ptr_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;
    logic [N-1:0][WIDTH-1:0] sq;
    always_ff @(posedge clk or posedge rst)
        if (rst) sq <= '0;
        else sq <= {sq[N-2:0], d};
    assign q = sq[N-1];
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side pointer, empty flag and show-ahead output register of the dual-clock FIFO.
// Define RD_AEMPTY_EN to add the registered raempty output.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  rempty,
    output logic [ADDR_WIDTH:0]   rcount
`ifdef RD_AEMPTY_EN
    ,
    output logic                  raempty
`endif
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [ADDR_WIDTH:0] rbin, rbin_next, rgray_next, wq_last, wbin;
    logic pop;
    ptr_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wsync (
        .clk(rclk),
        .rst(rrst),
        .d  (wptr_gray),
        .q  (wq_last)
    );
    always_comb begin
        pop = !rempty && (!rvalid || rready);
        rbin_next = pop ? rbin + PW'(1) : rbin;
        rgray_next = PW'(bin2gray(32'(rbin_next)));
        wbin = PW'(gray2bin(32'(wq_last)));
    end
    assign raddr = rbin[ADDR_WIDTH-1:0];
    assign rcount = wbin - rbin;
    // Empty is judged against the post-pop pointer so the last word is never read twice.
    always_ff @(posedge rclk or posedge rrst)
        if (rrst) begin
            rbin <= '0;
            rptr_gray <= '0;
            rempty <= 1'b1;
            rvalid <= 1'b0;
            rdata <= '0;
        end else begin
            rbin <= rbin_next;
            rptr_gray <= rgray_next;
            rempty <= rgray_next == wq_last;
            rvalid <= pop || (rvalid && !rready);
            if (pop) rdata <= mem_rdata;
        end
`ifdef RD_AEMPTY_EN
    logic [ADDR_WIDTH:0] count_next;
    assign count_next = wbin - rbin_next;
    always_ff @(posedge rclk or posedge rrst)
        if (rrst) raempty <= 1'b1;
        else raempty <= count_next <= PW'(AEMPTY_THRESH);
`endif
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: randomized and directed checks of fifo_read_ctrl against a queue-based FIFO model.
module tb_fifo_read_ctrl;
    localparam int AW = 3;
    localparam int DEPTH = 1 << AW;
    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic [AW:0]   wptr_gray = '0;
    logic [7:0]    mem_rdata;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr_gray;
    logic [7:0]    rdata;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          rempty;
    logic [AW:0]   rcount;
`ifdef RD_AEMPTY_EN
    logic          raempty;
`endif
    logic [7:0] mem [DEPTH];
    logic [7:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int wcount = 0;
    int delivered = 0;
    bit mon_en = 0;
    bit hold_prev = 0;
    logic [7:0] hold_data = '0;
    logic [AW:0] prev_gray = '0;

    fifo_read_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .SYNC_STAGES(2), .AEMPTY_THRESH(4)) u_dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .wptr_gray(wptr_gray),
        .mem_rdata(mem_rdata),
        .raddr    (raddr),
        .rptr_gray(rptr_gray),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rready   (rready),
        .rempty   (rempty),
        .rcount   (rcount)
`ifdef RD_AEMPTY_EN
        ,
        .raempty  (raempty)
`endif
    );

    always #5 rclk = ~rclk;
    assign mem_rdata = mem[raddr];

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic cycle();
        @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wcount % DEPTH] = d;
        wcount++;
        wptr_gray = to_gray(wcount);
        exp_q.push_back(d);
    endtask

    // Scoreboard: in-order delivery, output hold under backpressure, occupancy bound, Gray stepping.
    always @(negedge rclk) begin
        if (mon_en && !rrst) begin
            int occ;
            occ = wcount - delivered - (rvalid ? 1 : 0);
            tests++;
            if (int'(rcount) > occ || occ > DEPTH) begin
                fails++;
                $display("FAIL rcount_bound: rcount=%0d true occupancy=%0d", rcount, occ);
            end
            tests++;
            if ($countones(prev_gray ^ rptr_gray) > 1) begin
                fails++;
                $display("FAIL gray_step: rptr_gray %b -> %b", prev_gray, rptr_gray);
            end
            prev_gray = rptr_gray;
            if (hold_prev) begin
                tests++;
                if (rvalid !== 1'b1 || rdata !== hold_data) begin
                    fails++;
                    $display("FAIL hold_stable: rvalid=%b rdata=%h expected rvalid=1 rdata=%h", rvalid, rdata, hold_data);
                end
            end
            hold_prev = rvalid && !rready;
            hold_data = rdata;
            if (rvalid && rready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL order: got %h with nothing expected", rdata);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        fails++;
                        $display("FAIL order: rdata=%h expected %h", rdata, e);
                    end
                end
                delivered++;
            end
        end
    end

    task automatic test_reset();
        rrst = 1'b1;
        rready = 1'b0;
        wptr_gray = '0;
        repeat (3) cycle();
        rrst = 1'b0;
        cycle();
        tests++;
        if (rempty !== 1'b1 || rvalid !== 1'b0 || raddr !== '0 || rcount !== '0 || rptr_gray !== '0 || rdata !== '0) begin
            fails++;
            $display("FAIL reset_state: rempty=%b rvalid=%b raddr=%0d rcount=%0d rptr_gray=%0d rdata=%h expected 1 0 0 0 0 00",
                     rempty, rvalid, raddr, rcount, rptr_gray, rdata);
        end
`ifdef RD_AEMPTY_EN
        tests++;
        if (raempty !== 1'b1) begin
            fails++;
            $display("FAIL reset_raempty: raempty=%b expected 1", raempty);
        end
`endif
        rready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            tests++;
            if (rvalid !== 1'b0 || raddr !== '0) begin
                fails++;
                $display("FAIL idle_no_pop: cycle %0d rvalid=%b raddr=%0d expected 0 0", i, rvalid, raddr);
            end
        end
        prev_gray = '0;
        mon_en = 1;
    endtask

    task automatic test_single();
        rready = 1'b1;
        write_word(8'h21);
        cycle();
        cycle();
        tests++;
        if (rvalid !== 1'b0 || rempty !== 1'b1) begin
            fails++;
            $display("FAIL single_early: rvalid=%b rempty=%b expected 0 1", rvalid, rempty);
        end
        cycle();
        tests++;
        if (rvalid !== 1'b0 || rempty !== 1'b0) begin
            fails++;
            $display("FAIL single_empty_fall: rvalid=%b rempty=%b expected 0 0", rvalid, rempty);
        end
        cycle();
        tests++;
        if (rvalid !== 1'b1 || rdata !== 8'h21 || rempty !== 1'b1 || rptr_gray !== to_gray(1)) begin
            fails++;
            $display("FAIL single_pop: rvalid=%b rdata=%h rempty=%b rptr_gray=%b expected 1 21 1 %b",
                     rvalid, rdata, rempty, rptr_gray, to_gray(1));
        end
        cycle();
        tests++;
        if (rvalid !== 1'b0) begin
            fails++;
            $display("FAIL single_consumed: rvalid=%b expected 0", rvalid);
        end
    endtask

    task automatic test_backpressure();
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_word(8'h10 + 8'(i));
            cycle();
        end
        repeat (5) cycle();
        tests++;
        if (rvalid !== 1'b1 || rdata !== 8'h10 || rcount !== 4'(3)) begin
            fails++;
            $display("FAIL backpressure_hold: rvalid=%b rdata=%h rcount=%0d expected 1 10 3", rvalid, rdata, rcount);
        end
        rready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cycle();
            tests++;
            if (rvalid !== 1'b1 || rdata !== 8'h10 + 8'(i)) begin
                fails++;
                $display("FAIL back_to_back: rvalid=%b rdata=%h expected 1 %h", rvalid, rdata, 8'h10 + 8'(i));
            end
        end
        cycle();
        tests++;
        if (rvalid !== 1'b0 || rempty !== 1'b1) begin
            fails++;
            $display("FAIL drain_done: rvalid=%b rempty=%b expected 0 1", rvalid, rempty);
        end
    endtask

    task automatic test_stream_wrap();
        int sent = 0;
        int budget = 2000;
        while ((sent < 20 || delivered < wcount) && budget > 0) begin
            rready = $urandom_range(3) != 0;
            if (sent < 20 && wcount - delivered < DEPTH && $urandom_range(1) == 1) begin
                write_word(8'($urandom));
                sent++;
            end
            cycle();
            budget--;
        end
        rready = 1'b1;
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL stream_timeout: delivered=%0d expected %0d", delivered, wcount);
        end
        tests++;
        if (rptr_gray !== to_gray(wcount) || exp_q.size() != 0 || rempty !== 1'b1) begin
            fails++;
            $display("FAIL stream_end: rptr_gray=%b left=%0d rempty=%b expected %b 0 1",
                     rptr_gray, exp_q.size(), rempty, to_gray(wcount));
        end
    endtask

`ifdef RD_AEMPTY_EN
    task automatic test_aempty();
        int budget = 100;
        rready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write_word(8'h40 + 8'(i));
            cycle();
        end
        repeat (5) cycle();
        tests++;
        if (rcount !== 4'(5) || raempty !== 1'b0) begin
            fails++;
            $display("FAIL aempty_above: rcount=%0d raempty=%b expected 5 0", rcount, raempty);
        end
        rready = 1'b1;
        cycle();
        rready = 1'b0;
        tests++;
        if (rcount !== 4'(4) || raempty !== 1'b1) begin
            fails++;
            $display("FAIL aempty_at: rcount=%0d raempty=%b expected 4 1", rcount, raempty);
        end
        rready = 1'b1;
        while (delivered < wcount && budget > 0) begin
            cycle();
            budget--;
        end
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL aempty_drain_timeout: delivered=%0d expected %0d", delivered, wcount);
        end
    endtask
`endif

    task automatic test_reset_midburst();
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write_word(8'h70 + 8'(i));
            cycle();
        end
        repeat (5) cycle();
        tests++;
        if (rvalid !== 1'b1) begin
            fails++;
            $display("FAIL midburst_pre: rvalid=%b expected 1", rvalid);
        end
        @(negedge rclk);
        #2;
        mon_en = 0;
        rrst = 1'b1;
        #1;
        tests++;
        if (rvalid !== 1'b0 || rempty !== 1'b1 || rdata !== '0 || rcount !== '0 || rptr_gray !== '0 || raddr !== '0) begin
            fails++;
            $display("FAIL async_reset: rvalid=%b rempty=%b rdata=%h rcount=%0d rptr_gray=%0d raddr=%0d expected 0 1 00 0 0 0",
                     rvalid, rempty, rdata, rcount, rptr_gray, raddr);
        end
`ifdef RD_AEMPTY_EN
        tests++;
        if (raempty !== 1'b1) begin
            fails++;
            $display("FAIL async_reset_raempty: raempty=%b expected 1", raempty);
        end
`endif
        wcount = 0;
        delivered = 0;
        exp_q.delete();
        wptr_gray = '0;
        hold_prev = 0;
        prev_gray = '0;
        cycle();
        rrst = 1'b0;
        cycle();
        mon_en = 1;
        rready = 1'b1;
        write_word(8'h5A);
        repeat (5) cycle();
        tests++;
        if (delivered != 1 || rptr_gray !== to_gray(1) || rvalid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_word: delivered=%0d rptr_gray=%b rvalid=%b expected 1 %b 0",
                     delivered, rptr_gray, rvalid, to_gray(1));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream_wrap();
`ifdef RD_AEMPTY_EN
        test_aempty();
`endif
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the team's dual-clock FIFO. It owns the read pointer, synchronizes the write-domain Gray pointer into the read clock, and generates `rempty`. It drives `raddr` into the FIFO memory's asynchronous read port and presents the returned word through a show-ahead output register with a valid/ready handshake. It mirrors the write-side logic around the shared `memory` block.

## Interface
- `DATA_WIDTH`, 8, word width; must match the memory.
- `ADDR_WIDTH`, 8, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `SYNC_STAGES`, 2, flop stages on the incoming write pointer; minimum 2.
- `AEMPTY_THRESH`, 4, almost-empty threshold; only used when `RD_AEMPTY_EN` is defined.
- `rclk` in 1: read clock. The block has one clock.
- `rrst` in 1: reset, asynchronous and active-high.
- `wptr_gray` in ADDR_WIDTH+1: write pointer, Gray-coded, from the write domain.
- `mem_rdata` in DATA_WIDTH: memory read data, combinational from `raddr`.
- `raddr` out ADDR_WIDTH: memory read address.
- `rptr_gray` out ADDR_WIDTH+1: registered Gray read pointer, sent to the write domain.
- `rdata` out DATA_WIDTH: output word.
- `rvalid` out 1: `rdata` is valid.
- `rready` in 1: consumer accepts `rdata`.
- `rempty` out 1: no unread words in memory, as seen by the read domain.
- `rcount` out ADDR_WIDTH+1: memory occupancy, excluding the output register.
- `raempty` out 1: `rcount` <= `AEMPTY_THRESH`; present only when `RD_AEMPTY_EN` is defined.

## Operation
- State: binary pointer `rbin`, Gray pointer `rgray`, sync chain `wq[SYNC_STAGES]`, `rempty`, `rvalid`, `rdata`.
- Reset (`rrst` = 1, asynchronous):
  - `rbin`, `rgray`, all sync stages, `rdata` and `rcount` go to 0.
  - `rvalid` = 0, `rempty` = 1, `raempty` = 1.
- `raddr` = `rbin[ADDR_WIDTH-1:0]`.
- `pop` = `!rempty && (!rvalid || rready)`.
- On `pop`:
  - `rdata <= mem_rdata`, `rvalid <= 1`.
  - `rbin <= rbin+1`, `rgray <= bin2gray(rbin+1)`.
- Else, if `rvalid && rready`: `rvalid <= 0`.
- `rempty` is registered: `rempty <= (rgray_next == wq[SYNC_STAGES-1])`, where `rgray_next` is the Gray code of the post-pop pointer. This prevents over-read on the cycle the last word is popped.
- `rcount` = `gray2bin(wq_last) - rbin`, modulo 2^(ADDR_WIDTH+1), from registered signals. Its range is 0 to 2^ADDR_WIDTH.
- Pointer wrap is natural overflow of the ADDR_WIDTH+1-bit counter. The MSB distinguishes full from empty on the write side.
- Simultaneous pop and consumer accept: the new word replaces the old one and `rvalid` stays 1. Sustained throughput is one word per cycle.
- `rdata` must hold stable while `rvalid && !rready`.
- Reset mid-stream: in-flight output data is discarded and pointers return to 0. The write side must be reset in the same window; the block does not check this.

## Timing
- Write-to-read latency: `wptr_gray` changes before rclk edge k.
  - Edge k+SYNC_STAGES-1: the synced pointer updates.
  - Edge k+SYNC_STAGES: `rempty` falls.
  - Edge k+SYNC_STAGES+1: `rvalid` rises. With the default, that is 3 edges after the write.
- `rptr_gray` updates on the same edge as the pop. It is a direct flop output with no combinational logic, so it is safe for CDC.
- `rcount` can lag the true occupancy by up to SYNC_STAGES cycles. It never over-reports.

## Configuration
- `RD_AEMPTY_EN` defined:
  - The `raempty` port and its compare logic exist.
  - `raempty` is registered, and updates on the same edge as `rempty`.
- `RD_AEMPTY_EN` undefined: the port is absent and `AEMPTY_THRESH` is ignored. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` functions, parameterized by width.
  - A `ptr_t` typedef sized ADDR_WIDTH+1.
  - The `MIN_SYNC_STAGES = 2` constant.
- Sub-module `ptr_sync`: a SYNC_STAGES-deep flop chain of ADDR_WIDTH+1 bits on `rclk`/`rrst`, reset to 0. It is reused by the write side.

## Test plan
- Reset with `wptr_gray` = 0 → `rempty` = 1, `rvalid` = 0, `raddr` = 0, `rcount` = 0. No pop occurs for 10 cycles.
- Write 0x21 at address 0, then `wptr_gray` = 1, `rready` = 1 → `rvalid` rises 3 edges later with `rdata` = 0x21. `rempty` returns to 1 and `rptr_gray` = 1.
- Preload 4 words (0x10–0x13), hold `rready` = 0 → `rvalid` = 1 and `rdata` = 0x10 stays stable. `rcount` = 3. Releasing `rready` delivers one word per cycle in order.
- ADDR_WIDTH = 3, stream 20 words → in-order data with no loss across two pointer wraps. `rptr_gray` changes exactly one bit per increment.
- Assert `rrst` mid-burst with `rvalid` = 1 → all outputs return to reset values immediately, without waiting for a clock edge.
- `RD_AEMPTY_EN`, threshold 4, 6 words preloaded → `raempty` = 0 at `rcount` = 5 and `raempty` = 1 once `rcount` = 4.
